// File: rtl/ippcrc_pkg.sv
// Shared definitions for the ippcrc CRC blocks: polynomial constants,
// packet FSM states and the residue ("magic") constant helper.
package ippcrc_pkg;

    localparam logic [11:0] CRC12_POLY       = 12'h80F;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Residue left in the register after a frame whose trailing CRC was
    // inverted by xorout: (xorout * x^crc_w) mod poly, i.e. xorout shifted
    // MSB first through an all-zero register.
    function automatic logic [31:0] crc_magic(input logic [31:0] poly,
                                              input logic [31:0] xorout,
                                              input int unsigned crc_w = 32);
        logic [31:0] r;
        logic [31:0] mask;
        logic        fb;
        mask = (crc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << crc_w) - 32'd1);
        r    = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(crc_w)) begin
                fb = r[crc_w-1] ^ xorout[i];
                r  = ((r << 1) ^ (fb ? poly : 32'd0)) & mask;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ippcrc_crc_fold.sv
// Combinational fold of one data word into a CRC register. Bits are taken
// data_i[0] first; bytes whose enable is low are skipped entirely (not
// folded as zeros), so a partial word is exactly a shorter message.
module ippcrc_crc_fold
    import ippcrc_pkg::*;
#(
    parameter int               CRC_W = 12,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC12_POLY),
    parameter int               DAT_W = 56
) (
    input  logic [CRC_W-1:0]   seed_i,
    input  logic [DAT_W-1:0]   data_i,
    input  logic [DAT_W/8-1:0] byte_en_i,
    output logic [CRC_W-1:0]   crc_o
);

    logic [CRC_W-1:0] crc;
    logic             fb;

    // Unrolled bit-serial shift-XOR over the enabled bytes.
    // NOTE: blocking assignments here build a chain of combinational stages
    // within one evaluation; each iteration sees the previous one's result.
    always_comb begin
        crc = seed_i;
        fb  = 1'b0;
        for (int i = 0; i < DAT_W; i++) begin
            if (byte_en_i[i/8]) begin
                fb  = crc[CRC_W-1] ^ data_i[i];
                crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        crc_o = crc;
    end

endmodule

// File: rtl/ippcrc_crcgen_seq.sv
// Packet-level sequential CRC generator / checker with valid/ready input,
// byte-granular last word and a registered result handshake.
// Optional feature macro: IPPCRC_FINAL_XOR_EN (adds XOROUT final inversion
// and a matching magic-residue comparison in check mode).
module ippcrc_crcgen_seq
    import ippcrc_pkg::*;
#(
    parameter int               CRC_W = 12,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC12_POLY),
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               DAT_W = 56,
    parameter int               NB_W  = $clog2(DAT_W/8) + 1
`ifdef IPPCRC_FINAL_XOR_EN
    , parameter logic [CRC_W-1:0] XOROUT = '1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DAT_W-1:0] di,
    input  logic             di_vld,
    input  logic             di_sop,
    input  logic             di_eop,
    input  logic [NB_W-1:0]  di_nb,
    output logic             di_rdy,
    input  logic             chk_mode,
    output logic [CRC_W-1:0] crc_o,
    output logic             crc_err,
    output logic             crc_vld,
    input  logic             crc_rdy
);

    localparam int NBYTES = DAT_W / 8;
`ifdef IPPCRC_FINAL_XOR_EN
    localparam logic [CRC_W-1:0] MAGIC = CRC_W'(crc_magic(32'(POLY), 32'(XOROUT), CRC_W));
`endif

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic             accept;
    logic             restart;
    logic [CRC_W-1:0] seed;
    logic [NB_W-1:0]  nb_eff;
    logic [NBYTES-1:0] byte_en;
    logic [CRC_W-1:0] fold_out;
    logic [CRC_W-1:0] crc_res;
    logic             err_res;

    // Input is taken in IDLE and RUN only; the DONE cycle is the packet bubble.
    assign di_rdy  = !rst && (state_q != DONE);
    assign accept  = di_vld && di_rdy;
    assign crc_vld = (state_q == DONE);
    assign crc_o   = res_q;
    assign crc_err = err_q;

    // Start-of-packet selection: a sop (in IDLE or mid-RUN) reseeds and relatches the mode.
    always_comb begin
        restart = accept && di_sop;
        seed    = restart ? INIT : crc_q;
        mode_d  = restart ? chk_mode : mode_q;
    end

    // Byte enables: full word unless eop, then the low di_nb bytes (0 or oversize = full).
    always_comb begin
        nb_eff = di_nb;
        if (di_nb == '0 || di_nb > NB_W'(NBYTES)) nb_eff = NB_W'(NBYTES);
        for (int b = 0; b < NBYTES; b++) begin
            byte_en[b] = !di_eop || (NB_W'(b) < nb_eff);
        end
    end

    ippcrc_crc_fold #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .DAT_W (DAT_W)
    ) u_fold (
        .seed_i    (seed),
        .data_i    (di),
        .byte_en_i (byte_en),
        .crc_o     (fold_out)
    );

    // Published result and error flag for a packet ending this cycle.
    always_comb begin
`ifdef IPPCRC_FINAL_XOR_EN
        crc_res = mode_d ? fold_out : (fold_out ^ XOROUT);
        err_res = mode_d && (fold_out != MAGIC);
`else
        crc_res = fold_out;
        err_res = mode_d && (fold_out != '0);
`endif
    end

    // Packet FSM next state and register updates.
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept && di_sop) begin
                    crc_d   = fold_out;
                    state_d = di_eop ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    crc_d = fold_out;
                    if (di_eop) state_d = DONE;
                end
            end
            DONE: begin
                if (crc_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) begin
            res_d = crc_res;
            err_d = err_res;
        end
    end

    // State and datapath registers with synchronous reset.
    // NOTE: non-blocking assignments so all registers update together from
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            mode_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ippcrc_crcgen_seq.sv
// Self-checking bench for ippcrc_crcgen_seq (default parameters). Expected
// results come from a bit-serial reference model and are queued when the
// packet is driven, then popped when the DUT presents its result.
module tb_ippcrc_crcgen_seq;

    localparam int CRC_W = 12;
    localparam int DAT_W = 56;
    localparam int NB_W  = 4;
`ifdef IPPCRC_FINAL_XOR_EN
    localparam logic [11:0] K_ZERO = 12'hFFF;
    localparam logic [11:0] K_ONE  = 12'h7F0;
`else
    localparam logic [11:0] K_ZERO = 12'h000;
    localparam logic [11:0] K_ONE  = 12'h80F;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [DAT_W-1:0] di;
    logic             di_vld, di_sop, di_eop, di_rdy, chk_mode;
    logic [NB_W-1:0]  di_nb;
    logic [CRC_W-1:0] crc_o;
    logic             crc_err, crc_vld, crc_rdy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [12:0] exp_q[$];   // {err, crc}

    always #5 clk = ~clk;

    ippcrc_crcgen_seq #(
        .CRC_W (12),
        .POLY  (12'h80F),
        .INIT  (12'h000),
        .DAT_W (56)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .di       (di),
        .di_vld   (di_vld),
        .di_sop   (di_sop),
        .di_eop   (di_eop),
        .di_nb    (di_nb),
        .di_rdy   (di_rdy),
        .chk_mode (chk_mode),
        .crc_o    (crc_o),
        .crc_err  (crc_err),
        .crc_vld  (crc_vld),
        .crc_rdy  (crc_rdy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference: MSB-first CRC-12, message bits in line order.
    function automatic logic [11:0] ref_crc(input bit s[$]);
        logic [11:0] c;
        logic        fb;
        c = 12'h000;
        foreach (s[i]) begin
            fb = c[11] ^ s[i];
            c  = {c[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
        end
        return c;
    endfunction

    function automatic logic [12:0] expect_of(input bit s[$], input logic mode);
        logic [11:0] r;
        r = ref_crc(s);
`ifdef IPPCRC_FINAL_XOR_EN
        begin
            bit          ones[$];
            logic [11:0] magic;
            for (int i = 0; i < 12; i++) ones.push_back(1'b1);
            magic = ref_crc(ones);
            return {mode & (r != magic), (mode ? r : (r ^ 12'hFFF))};
        end
`else
        return {mode & (r != 12'h000), r};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word, holding it until accepted (bounded wait).
    task automatic send(input logic [55:0] d, input logic sop, input logic eop,
                        input logic [3:0] nb, input logic mode);
        int n;
        n = 0;
        @(negedge clk);
        di = d; di_sop = sop; di_eop = eop; di_nb = nb; di_vld = 1'b1;
        chk_mode = sop ? mode : ~mode;
        while (!di_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!di_rdy) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout di_rdy=%0b required=1", di_rdy);
        end
        tick();
        di_vld = 1'b0; di_sop = 1'b0; di_eop = 1'b0;
    endtask

    // Pack a byte-multiple bit stream into words; unused bits get random junk.
    task automatic send_stream(input bit s[$], input logic mode, input bit push);
        int          nbits, pos, take;
        logic [63:0] r64;
        logic [55:0] w;
        logic        last;
        logic [3:0]  nb;
        nbits = s.size();
        pos   = 0;
        if (push) exp_q.push_back(expect_of(s, mode));
        while (pos < nbits) begin
            r64  = {$urandom(), $urandom()};
            w    = r64[55:0];
            take = (nbits - pos > 56) ? 56 : (nbits - pos);
            for (int i = 0; i < take; i++) w[i] = s[pos + i];
            last = (pos + take == nbits);
            nb   = last ? 4'((take + 7) / 8) : 4'($urandom_range(0, 15));
            send(w, pos == 0, last, nb, mode);
            pos += take;
        end
    endtask

    // Wait (bounded) for crc_vld, sampling at the falling edge.
    task automatic get_result(output logic [11:0] c, output logic e, output int lat);
        lat = 0;
        @(negedge clk);
        while (!crc_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        c = crc_o;
        e = crc_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; di = '0; di_vld = 0; di_sop = 0; di_eop = 0; di_nb = '0;
        chk_mode = 0; crc_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_di_rdy got=%0b want=0", di_rdy); end
        n_assert++; if (crc_vld !== 1'b0) begin n_fail++; $display("FAIL reset_crc_vld got=%0b want=0", crc_vld); end
        n_assert++; if (crc_o !== 12'h000) begin n_fail++; $display("FAIL reset_crc_o got=%h want=000", crc_o); end
        n_assert++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err got=%0b want=0", crc_err); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_di_rdy got=%0b want=1", di_rdy); end
    endtask

    task automatic test_known_vectors();
        bit          s[$];
        logic [11:0] c, c0;
        logic        e;
        int          lat;
        logic [12:0] ex;
        // All-zero 7-byte message, result held while crc_rdy = 0.
        crc_rdy = 1'b0;
        for (int i = 0; i < 56; i++) s.push_back(1'b0);
        send_stream(s, 1'b0, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (lat !== 0) begin n_fail++; $display("FAIL zero_latency got=%0d want=0", lat); end
        n_assert++; if (c !== ex[11:0]) begin n_fail++; $display("FAIL zero_crc_model got=%h want=%h", c, ex[11:0]); end
        n_assert++; if (c !== K_ZERO) begin n_fail++; $display("FAIL zero_crc_const got=%h want=%h", c, K_ZERO); end
        c0 = c;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_assert++; if (crc_vld !== 1'b1 || crc_o !== c0) begin
                n_fail++; $display("FAIL zero_hold vld=%0b crc=%h want vld=1 crc=%h", crc_vld, crc_o, c0);
            end
        end
        crc_rdy = 1'b1;
        tick();
        // Message = 1 (only di[7] set in a 1-byte word).
        s.delete();
        for (int i = 0; i < 7; i++) s.push_back(1'b0);
        s.push_back(1'b1);
        send_stream(s, 1'b0, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c !== ex[11:0] || e !== ex[12]) begin n_fail++; $display("FAIL one_crc_model got=%h/%0b want=%h/%0b", c, e, ex[11:0], ex[12]); end
        n_assert++; if (c !== K_ONE) begin n_fail++; $display("FAIL one_crc_const got=%h want=%h", c, K_ONE); end
        tick();
    endtask

    task automatic test_packet_gen_check();
        bit          msg[$], frame[$];
        logic [11:0] c, tail;
        logic        e;
        int          lat;
        logic [12:0] ex;
        for (int i = 0; i < 152; i++) msg.push_back(bit'($urandom_range(0, 1)));
        send_stream(msg, 1'b0, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (lat !== 0) begin n_fail++; $display("FAIL gen_latency got=%0d want=0", lat); end
        n_assert++; if (c !== ex[11:0] || e !== ex[12]) begin n_fail++; $display("FAIL gen_crc got=%h/%0b want=%h/%0b", c, e, ex[11:0], ex[12]); end
        tick();
        // Leading zeros leave an INIT=0 CRC unchanged; they byte-align the frame.
        tail = ex[11:0];
        for (int i = 0; i < 4; i++) frame.push_back(1'b0);
        foreach (msg[i]) frame.push_back(msg[i]);
        for (int b = 11; b >= 0; b--) frame.push_back(tail[b]);
        send_stream(frame, 1'b1, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c !== ex[11:0] || e !== ex[12]) begin n_fail++; $display("FAIL chk_good got=%h/%0b want=%h/%0b", c, e, ex[11:0], ex[12]); end
        n_assert++; if (e !== 1'b0) begin n_fail++; $display("FAIL chk_good_err got=%0b want=0", e); end
        tick();
        frame[20] = ~frame[20];
        send_stream(frame, 1'b1, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c !== ex[11:0] || e !== ex[12]) begin n_fail++; $display("FAIL chk_bad got=%h/%0b want=%h/%0b", c, e, ex[11:0], ex[12]); end
        n_assert++; if (e !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err got=%0b want=1", e); end
        tick();
    endtask

    task automatic test_backpressure();
        bit          s1[$], s2[$];
        logic [11:0] c, c1;
        logic        e;
        int          lat;
        logic [12:0] ex;
        logic [63:0] r64;
        logic [55:0] w2;
        crc_rdy = 1'b0;
        for (int i = 0; i < 56; i++) s1.push_back(bit'($urandom_range(0, 1)));
        send_stream(s1, 1'b0, 1'b1);
        get_result(c1, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c1 !== ex[11:0] || lat !== 0) begin n_fail++; $display("FAIL bp_first got=%h lat=%0d want=%h lat=0", c1, lat, ex[11:0]); end
        // Offer the next sop while the result is stalled.
        r64 = {$urandom(), $urandom()};
        w2  = r64[55:0];
        for (int i = 0; i < 56; i++) s2.push_back(w2[i]);
        exp_q.push_back(expect_of(s2, 1'b0));
        di = w2; di_sop = 1'b1; di_eop = 1'b1; di_nb = 4'd7; chk_mode = 1'b0; di_vld = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_assert++; if (crc_vld !== 1'b1 || di_rdy !== 1'b0 || crc_o !== c1) begin
                n_fail++; $display("FAIL bp_stall cyc=%0d vld=%0b rdy=%0b crc=%h want vld=1 rdy=0 crc=%h", k, crc_vld, di_rdy, crc_o, c1);
            end
        end
        crc_rdy = 1'b1;
        tick();
        @(negedge clk);
        n_assert++; if (crc_vld !== 1'b0 || di_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_bypass vld=%0b rdy=%0b want vld=0 rdy=1", crc_vld, di_rdy);
        end
        tick();
        di_vld = 1'b0; di_sop = 1'b0; di_eop = 1'b0;
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c !== ex[11:0] || e !== ex[12] || lat !== 0) begin
            n_fail++; $display("FAIL bp_second got=%h/%0b lat=%0d want=%h/%0b lat=0", c, e, lat, ex[11:0], ex[12]);
        end
        tick();
    endtask

    task automatic test_restart();
        bit          s[$];
        logic [11:0] c;
        logic        e;
        int          lat, extra;
        logic [12:0] ex;
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        send(r64[55:0], 1'b1, 1'b0, 4'd7, 1'b1);   // aborted packet, check mode
        for (int i = 0; i < 80; i++) s.push_back(bit'($urandom_range(0, 1)));
        send_stream(s, 1'b0, 1'b1);
        get_result(c, e, lat);
        ex = exp_q.pop_front();
        n_assert++; if (c !== ex[11:0] || e !== ex[12] || lat !== 0) begin
            n_fail++; $display("FAIL restart_crc got=%h/%0b lat=%0d want=%h/%0b lat=0", c, e, lat, ex[11:0], ex[12]);
        end
        tick();
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (crc_vld) extra++;
        end
        n_assert++; if (extra !== 0) begin n_fail++; $display("FAIL restart_single_result extra=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r64;
        int          seen;
        r64 = {$urandom(), $urandom()};
        send(r64[55:0], 1'b1, 1'b0, 4'd7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_assert++; if (di_rdy !== 1'b0 || crc_vld !== 1'b0 || crc_o !== 12'h000 || crc_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs rdy=%0b vld=%0b crc=%h err=%0b want 0/0/000/0", di_rdy, crc_vld, crc_o, crc_err);
        end
        @(negedge clk);
        rst = 1'b0;
        r64 = {$urandom(), $urandom()};
        send(r64[55:0], 1'b0, 1'b1, 4'd7, 1'b0);   // eop without sop: dropped
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (crc_vld) seen++;
        end
        n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_result seen=%0d want=0", seen); end
        n_assert++; if (crc_o !== 12'h000 || di_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_idle crc=%h rdy=%0b want 000/1", crc_o, di_rdy);
        end
    endtask

    task automatic test_nb_boundary();
        bit          s[$];
        logic [11:0] c;
        logic        e;
        int          lat;
        logic [12:0] ex;
        logic [63:0] r64;
        logic [3:0]  nbs[3];
        nbs[0] = 4'd0; nbs[1] = 4'd9; nbs[2] = 4'd15;
        for (int t = 0; t < 3; t++) begin
            r64 = {$urandom(), $urandom()};
            s.delete();
            for (int i = 0; i < 56; i++) s.push_back(r64[i]);
            exp_q.push_back(expect_of(s, 1'b0));
            send(r64[55:0], 1'b1, 1'b1, nbs[t], 1'b0);
            get_result(c, e, lat);
            ex = exp_q.pop_front();
            n_assert++; if (c !== ex[11:0] || lat !== 0) begin
                n_fail++; $display("FAIL nb_full nb=%0d got=%h lat=%0d want=%h lat=0", nbs[t], c, lat, ex[11:0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_packet_gen_check();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_nb_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ippcrc_crcgen_seq.md
Name: ippcrc_crcgen_seq

Overview:
- Parametrised, sequential, packet-level CRC generator and checker. It generalises the fixed 12-bit, 56-bit-wide combinational CRC core to any CRC width, polynomial and data width.
- Accumulates the CRC over multi-word packets with a valid/ready handshake, partial last words (byte granularity), a registered result handshake, and a residue-check mode.
- Sits in the ippcrc package between the framer datapath and the FEC/ECC blocks.

Parameters:
- CRC_W, 12, CRC width in bits (4..32).
- POLY, 12'h80F, generator polynomial without the implicit x^CRC_W term (CRC-12 default).
- INIT, 0, CRC register value loaded at start of packet.
- DAT_W, 56, data word width; must be a multiple of 8.
- NB_W, $clog2(DAT_W/8)+1, width of the byte-count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- di  in  DAT_W  data word; di[0] is the first bit on the line
- di_vld  in  1  data word valid
- di_sop  in  1  first word of packet (qualified by di_vld)
- di_eop  in  1  last word of packet (qualified by di_vld)
- di_nb  in  NB_W  valid bytes in the eop word, 1..DAT_W/8; bytes fill from di[7:0] upward; ignored when not eop
- di_rdy  out  1  block accepts a word this cycle
- chk_mode  in  1  sampled with the sop word: 0 = generate, 1 = check (packet includes trailing CRC)
- crc_o  out  CRC_W  final CRC (generate) or residue (check)
- crc_err  out  1  check mode only: residue != 0
- crc_vld  out  1  result valid
- crc_rdy  in  1  result consumer ready

Behaviour:
- Accept condition: di_vld & di_rdy. di_rdy = 1 in IDLE and RUN; di_rdy = 0 in DONE.
- Bit order: bits are processed di[0] first, di[DAT_W-1] last. A single-cycle fold of up to DAT_W bits uses shift-XOR with POLY.
- FSM:
  - IDLE:
    - Words without sop are dropped silently; the CRC register is unchanged.
    - Accepted sop word: seed = INIT, fold the word into crc_q, latch chk_mode into mode_q.
    - Go to DONE if eop is also set, else go to RUN.
  - RUN:
    - Accepted word: seed = crc_q.
    - A sop inside RUN restarts the packet: seed = INIT, mode_q re-latched, no result emitted for the aborted packet.
    - Go to DONE on eop.
  - DONE:
    - crc_vld = 1; crc_o and crc_err are stable.
    - Exit to IDLE when crc_rdy = 1. di_rdy stays 0 until that cycle completes (no bypass).
- Partial last word:
  - Only bits [8*di_nb-1:0] are folded; the remaining bits are ignored, not zero-folded.
  - di_nb = 0 or di_nb > DAT_W/8 is treated as DAT_W/8.
- Latency: eop accepted in cycle N gives crc_vld = 1 in cycle N+1. Throughput: 1 word/cycle within a packet, plus at least 1 bubble per packet (DONE).
- crc_err = mode_q & (crc_o != 0). It is 0 in generate mode.
- Reset: state = IDLE; crc_q = INIT; mode_q = 0; crc_o = 0; crc_vld = 0; crc_err = 0; di_rdy = 0 during the reset cycle and 1 afterwards. Reset mid-packet discards the packet; no result is emitted.
- Simultaneous sop & eop on one word: single-word packet, handled as above.

Optional Feature:
- Macro: IPPCRC_FINAL_XOR_EN.
- When defined:
  - Adds parameter XOROUT (default all-ones).
  - Generate mode: crc_o = crc_q ^ XOROUT.
  - Check mode: the residue is compared against the magic constant ((XOROUT·x^CRC_W) mod POLY) rather than 0.
  - crc_o stays the raw register value.
- When undefined: no XOROUT logic; crc_o = crc_q.

Decomposition:
- Package ippcrc_pkg holds:
  - Polynomial constants: CRC12_POLY = 12'h80F, CRC16_CCITT_POLY, CRC32_POLY.
  - FSM state enum: IDLE, RUN, DONE.
  - Function crc_magic(poly, xorout).
- Sub-module ippcrc_crc_fold: combinational, parametrised by CRC_W, POLY and DAT_W.
  - Inputs: seed, data, byte mask.
  - Output: next CRC.
  - Reused by later parallel/multi-lane CRC blocks.

Test Plan:
- Default parameters, INIT = 0, single sop+eop word, di = 0, di_nb = 7 -> crc_o = 12'h000 one cycle later; crc_vld held while crc_rdy = 0.
- Single sop+eop word, di_nb = 1, only di[7] = 1 (message = 1) -> crc_o = 12'h80F (= x^12 mod P).
- 3-word packet of random data with di_nb = 5 in the last word, generate mode -> crc_o matches the bit-serial reference model. Then resend the data plus the CRC (MSB first) in check mode -> crc_o = 0, crc_err = 0. Flip one data bit -> crc_err = 1.
- Backpressure: crc_rdy = 0 for 10 cycles -> di_rdy = 0 throughout, crc_vld/crc_o stable; the next sop is accepted only in the cycle after the handshake.
- sop arrives mid-packet, then eop -> exactly one result, equal to the CRC of the second packet only. rst asserted mid-packet -> no crc_vld; all outputs at reset values.
- IPPCRC_FINAL_XOR_EN with XOROUT = 12'hFFF -> generate output = raw CRC ^ 12'hFFF; check mode on the XORed frame -> crc_err = 0.
